// File: rtl/vga_pkg.sv
// VGA timing package: default 640x480@60 timing, sync polarity,
// coordinate width and the registered sync bundle shared by VGA blocks.
package vga_pkg;

  localparam int COORD_W = 16;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT
                               + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT
                               + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_CLK_DIV   = 4;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video;
  } sync_t;

  function automatic logic in_span(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus from the VGA timing generator to its consumers:
// pixel enable, raster position and registered sync/blank strobes.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic               p_tick;
  logic [COORD_W-1:0] xpixel;
  logic [COORD_W-1:0] ypixel;
  logic               video;
  logic               hsync;
  logic               vsync;
  logic               frame_start;

  modport master (
    output p_tick,
    output xpixel,
    output ypixel,
    output video,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input p_tick,
    input xpixel,
    input ypixel,
    input video,
    input hsync,
    input vsync,
    input frame_start
  );

endinterface

// File: rtl/pixel_tick_div.sv
// Pixel clock enable: counts 0..DIV-1 and flags the last count.
// Gated by reset so the enable is low while reset is applied.
module pixel_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam logic [3:0] LAST = 4'(DIV - 1);

  logic [3:0] cnt;

  assign p_tick = !reset && (cnt == LAST);

  // divider counter, wraps after the enable cycle
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters advanced by the pixel enable,
// sync/blank decoded from next-state counters so all outputs move together.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END =
    COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END =
    COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam sync_t SYNC_RST = '{
    hsync: ~SYNC_ACTIVE,
    vsync: ~SYNC_ACTIVE,
    video: 1'b1
  };

  logic               tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               wrap;
  sync_t              sync_q;
  sync_t              sync_d;
  logic               fs_q;

  pixel_tick_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  // next raster position; frame wrap when leaving the last pixel
  always_comb begin
    x_next = x;
    y_next = y;
    wrap   = 1'b0;
    if (tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        if (y == V_LAST) begin
          y_next = '0;
          wrap   = 1'b1;
        end else begin
          y_next = y + 16'd1;
        end
      end else begin
        x_next = x + 16'd1;
      end
    end
  end

  // sync and blank decoded from the position being loaded this edge
  always_comb begin
    sync_d       = SYNC_RST;
    sync_d.hsync = in_span(x_next, HS_BEG, HS_END)
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_d.vsync = in_span(y_next, VS_BEG, VS_END)
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_d.video = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // position, strobes and frame pulse; reset wins over any tick
  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      sync_q <= SYNC_RST;
      fs_q   <= 1'b0;
    end else begin
      x      <= x_next;
      y      <= y_next;
      sync_q <= sync_d;
      fs_q   <= wrap;
    end
  end

  assign vga.p_tick      = tick;
  assign vga.xpixel      = x;
  assign vga.ypixel      = y;
  assign vga.video       = sync_q.video;
  assign vga.hsync       = sync_q.hsync;
  assign vga.vsync       = sync_q.vsync;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing /4 instance plus a /1
// instance with a short frame, checked clock by clock against a model.
module tb_vga_timing_gen;

  logic clk;
  logic r4;
  logic r1;

  vga_timing_gen_if if4 ();
  vga_timing_gen_if if1 ();

  vga_timing_gen #(
    .CLK_DIV (4)
  ) dut4 (
    .clk   (clk),
    .reset (r4),
    .vga   (if4)
  );

  vga_timing_gen #(
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1),
    .CLK_DIV   (1)
  ) dut1 (
    .clk   (clk),
    .reset (r1),
    .vga   (if1)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        pt;
    logic        vid;
    logic        hs;
    logic        vs;
    logic        fs;
  } snap_t;

  snap_t q4[$];
  snap_t q1[$];

  int checks;
  int failures;
  int k4;
  int k1;
  int hs4_cnt;
  int vid4_cnt;
  int hs1_cnt;
  int vs1_cnt;
  int fs1_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k = clocks since the last reset edge; pixel index is k / d
  function automatic snap_t model(
    input int   k,
    input int   d,
    input int   vd,
    input int   vf,
    input int   vsw,
    input int   vt,
    input logic rst_now
  );
    snap_t s;
    int p;
    int xi;
    int yi;
    p  = k / d;
    xi = p % 800;
    yi = (p / 800) % vt;
    s.x   = 16'(xi);
    s.y   = 16'(yi);
    s.pt  = !rst_now && ((k % d) == d - 1);
    s.vid = (xi < 640) && (yi < vd);
    s.hs  = !((xi >= 656) && (xi <= 751));
    s.vs  = !((yi >= vd + vf) && (yi <= vd + vf + vsw - 1));
    s.fs  = (p > 0) && ((p % (800 * vt)) == 0) && ((k % d) == 0);
    return s;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    snap_t e4;
    snap_t e1;
    snap_t o4;
    snap_t o1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (r4) k4 = 0;
      else    k4++;
      if (r1) k1 = 0;
      else    k1++;
      q4.push_back(model(k4, 4, 480, 10, 2, 525, r4));
      q1.push_back(model(k1, 1, 4, 1, 2, 8, r1));
      #1;
      o4 = '{if4.xpixel, if4.ypixel, if4.p_tick, if4.video,
             if4.hsync, if4.vsync, if4.frame_start};
      o1 = '{if1.xpixel, if1.ypixel, if1.p_tick, if1.video,
             if1.hsync, if1.vsync, if1.frame_start};
      e4 = q4.pop_front();
      e1 = q1.pop_front();
      checks++;
      assert (o4 === e4) else begin
        failures++;
        $error("FAIL dut4_clk k=%0d observed=%h expected=%h", k4, o4, e4);
      end
      checks++;
      assert (o1 === e1) else begin
        failures++;
        $error("FAIL dut1_clk k=%0d observed=%h expected=%h", k1, o1, e1);
      end
      if (k4 == 0) begin
        hs4_cnt  = 0;
        vid4_cnt = 0;
      end else if (k4 <= 3200) begin
        if (o4.hs !== 1'b1)  hs4_cnt++;
        if (o4.vid !== 1'b1) vid4_cnt++;
      end
      if (k1 == 0) begin
        hs1_cnt = 0;
        vs1_cnt = 0;
        fs1_cnt = 0;
      end else if (k1 <= 6400) begin
        if (o1.hs !== 1'b1) hs1_cnt++;
        if (o1.vs !== 1'b1) vs1_cnt++;
        if (o1.fs === 1'b1) fs1_cnt++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k4 = 0;
    k1 = 0;
    hs4_cnt = 0;
    vid4_cnt = 0;
    hs1_cnt = 0;
    vs1_cnt = 0;
    fs1_cnt = 0;
    r4 = 1'b1;
    r1 = 1'b1;

    step(3);
    chk("rst_x4", int'(if4.xpixel), 0);
    chk("rst_hs4", int'(if4.hsync), 1);
    chk("rst_vid4", int'(if4.video), 1);
    chk("rst_pt1", int'(if1.p_tick), 0);
    @(negedge clk);
    r4 = 1'b0;
    r1 = 1'b0;

    step(3);
    chk("first_tick4", int'(if4.p_tick), 1);
    step(1);
    chk("first_move4", int'(if4.xpixel), 1);

    step(3196);
    chk("line_hs4", hs4_cnt, 384);
    chk("line_vid4", vid4_cnt, 640);
    chk("line_x4", int'(if4.xpixel), 0);
    chk("line_y4", int'(if4.ypixel), 1);

    step(1500);
    chk("pre_rst_x1", int'(if1.xpixel), 700);
    chk("pre_rst_y1", int'(if1.ypixel), 5);
    @(negedge clk);
    r1 = 1'b1;
    step(1);
    chk("mid_rst_x1", int'(if1.xpixel), 0);
    chk("mid_rst_y1", int'(if1.ypixel), 0);
    chk("mid_rst_vs1", int'(if1.vsync), 1);
    @(negedge clk);
    r1 = 1'b0;

    step(1299);
    chk("pre_rst_x4", int'(if4.xpixel), 700);
    chk("pre_rst_y4", int'(if4.ypixel), 1);
    @(negedge clk);
    r4 = 1'b1;
    step(1);
    chk("mid_rst_x4", int'(if4.xpixel), 0);
    chk("mid_rst_hs4", int'(if4.hsync), 1);
    @(negedge clk);
    r4 = 1'b0;

    step(5100);
    chk("relin_hs4", hs4_cnt, 384);
    chk("relin_vid4", vid4_cnt, 640);
    chk("frame_hs1", hs1_cnt, 768);
    chk("frame_vs1", vs1_cnt, 1600);
    chk("frame_fs1", fs1_cnt, 1);
    chk("wrap_fs1", int'(if1.frame_start), 1);
    step(1);
    chk("fs_width1", int'(if1.frame_start), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
